// File: rtl/sort_engine_if.sv
// Host-side port of the sort engine: load/read bus, sort control and status.
interface sort_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int CNT_WIDTH  = 16
);
  logic                  start;
  logic                  desc;
  logic [ADDR_WIDTH:0]   len;
  logic                  wr;
  logic                  rd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;
  logic                  done;
  logic [CNT_WIDTH-1:0]  swap_cnt;

  modport master (
    output start, desc, len, wr, rd, addr, wdata,
    input  rdata, busy, done, swap_cnt
  );

  modport slave (
    input  start, desc, len, wr, rd, addr, wdata,
    output rdata, busy, done, swap_cnt
  );
endinterface

// File: rtl/sort_engine.sv
// In-place bubble sorter over a single-port DEPTH x DATA_WIDTH store.
// Host loads/reads words while idle; a sort of the first len words runs on
// start, exits early on a swap-free pass and reports the swap count.
module sort_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int CNT_WIDTH  = 16
) (
  input logic        clk,
  input logic        rstn,
  sort_engine_if.slave host
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LIM_ONE = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [3:0] {
    IDLE, INIT, RDA, RDB, CMP, SWA, SWB, PASS, DONE
  } state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] dout;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic                  mem_we;

  logic [ADDR_WIDTH-1:0] j;
  logic [ADDR_WIDTH:0]   lim;
  logic                  swapped;
  logic                  desc_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [CNT_WIDTH-1:0]  swap_cnt_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [ADDR_WIDTH:0]   len_c;
  logic [ADDR_WIDTH:0]   lim_n;
  logic                  last;
  logic                  do_swap;

  // Start-time limit: clamp len to DEPTH; len 0 and 1 both give lim 0.
  always_comb begin
    len_c = (host.len > DEPTH_L) ? DEPTH_L : host.len;
    lim_n = (len_c == '0) ? '0 : len_c - LIM_ONE;
  end

  // Pair (j, j+1) is the last of the pass; swap decision uses B straight from dout.
  always_comb begin
    last    = (({1'b0, j} + LIM_ONE) == lim);
    do_swap = desc_q ? (a_q < dout) : (a_q > dout);
  end

  // Single memory port: host owns it in IDLE, the sorter otherwise.
  always_comb begin
    mem_addr = host.addr;
    mem_wd   = host.wdata;
    mem_we   = 1'b0;
    case (state)
      IDLE: mem_we = host.wr;
      RDA:  mem_addr = j;
      RDB:  mem_addr = j + ADDR_WIDTH'(1);
      SWA: begin
        mem_addr = j;
        mem_wd   = b_q;
        mem_we   = 1'b1;
      end
      SWB: begin
        mem_addr = j + ADDR_WIDTH'(1);
        mem_wd   = a_q;
        mem_we   = 1'b1;
      end
      default: ;
    endcase
  end

  // Storage with synchronous read; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wd;
    dout <= mem[mem_addr];
  end

  // Host read register: loads in IDLE unless a write wins, forced to 0 by rd while busy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q <= '0;
    end else if (state != IDLE) begin
      if (host.rd) rdata_q <= '0;
    end else if (host.rd && !host.wr) begin
      rdata_q <= mem[mem_addr];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (host.start) state_nx = INIT;
      INIT:    state_nx = (lim == '0) ? DONE : RDA;
      RDA:     state_nx = RDB;
      RDB:     state_nx = CMP;
      CMP:     state_nx = do_swap ? SWA : (last ? PASS : RDA);
      SWA:     state_nx = SWB;
      SWB:     state_nx = last ? PASS : RDA;
      PASS:    state_nx = (!swapped || lim == LIM_ONE) ? DONE : RDA;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Sort datapath: index, pass limit, operands, swap flag and counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      j          <= '0;
      lim        <= '0;
      swapped    <= 1'b0;
      desc_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      swap_cnt_q <= '0;
    end else begin
      case (state)
        IDLE: if (host.start) begin
          desc_q     <= host.desc;
          lim        <= lim_n;
          swap_cnt_q <= '0;
        end
        INIT: begin
          j       <= '0;
          swapped <= 1'b0;
        end
        RDB: a_q <= dout;
        CMP: begin
          b_q <= dout;
          if (!do_swap && !last) j <= j + ADDR_WIDTH'(1);
        end
        SWB: begin
          swapped <= 1'b1;
          if (swap_cnt_q != '1) swap_cnt_q <= swap_cnt_q + CNT_WIDTH'(1);
          if (!last) j <= j + ADDR_WIDTH'(1);
        end
        PASS: begin
          if (swapped && lim != LIM_ONE) lim <= lim - LIM_ONE;
          j       <= '0;
          swapped <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign host.rdata    = rdata_q;
  assign host.busy     = (state != IDLE);
  assign host.done     = (state == DONE);
  assign host.swap_cnt = swap_cnt_q;

endmodule

// File: tb/tb_sort_engine.sv
// Self-checking bench for sort_engine: a bubble-sort reference model fills a
// scoreboard of expected contents when each sort is started; readback pops it.
module tb_sort_engine;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  sort_engine_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .CNT_WIDTH(16)) bus ();

  sort_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .CNT_WIDTH(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .host (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] shadow [8];
  logic [7:0] got    [8];
  logic [7:0] exp_q  [$];
  int exp_swaps, exp_cycles;
  int busy_cycles, done_pulses, done_at;

  // Reference bubble sort on shadow; pushes expected contents, swaps and busy length.
  task automatic model_sort(input int len_i, input bit desc_i);
    int n, lim;
    bit sw, go;
    logic [7:0] t;
    n = (len_i > 8) ? 8 : len_i;
    lim = n - 1;
    exp_swaps = 0;
    exp_cycles = 2;
    go = (lim > 0);
    while (go) begin
      sw = 1'b0;
      for (int k = 0; k < lim; k++) begin
        exp_cycles += 3;
        if (desc_i ? (shadow[k] < shadow[k+1]) : (shadow[k] > shadow[k+1])) begin
          t = shadow[k]; shadow[k] = shadow[k+1]; shadow[k+1] = t;
          sw = 1'b1;
          exp_swaps++;
          exp_cycles += 2;
        end
      end
      exp_cycles += 1;
      go = sw && (lim > 1);
      lim--;
    end
    for (int a = 0; a < 8; a++) exp_q.push_back(shadow[a]);
  endtask

  task automatic load_shadow();
    for (int a = 0; a < 8; a++) begin
      bus.wr = 1'b1; bus.addr = 3'(a); bus.wdata = shadow[a];
      @(posedge clk); #1;
    end
    bus.wr = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 8; a++) begin
      bus.rd = 1'b1; bus.addr = 3'(a);
      @(posedge clk); #1;
      got[a] = bus.rdata;
    end
    bus.rd = 1'b0;
  endtask

  // Pulse start, then count busy cycles and done pulses (cycle 1 = first after accept).
  task automatic run_sort(input int len_i, input bit desc_i);
    bus.len = 4'(len_i); bus.desc = desc_i; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.desc = ~desc_i; bus.len = '0;
    busy_cycles = 0; done_pulses = 0; done_at = 0;
    for (int i = 1; i <= 600; i++) begin
      if (bus.done) begin done_pulses++; done_at = i; end
      if (!bus.busy) break;
      busy_cycles++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    checks++; if (bus.rdata !== 8'd0) begin errors++; $display("FAIL reset_rdata got=%0h exp=0", bus.rdata); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.swap_cnt !== 16'd0) begin errors++; $display("FAIL reset_swap_cnt got=%0d exp=0", bus.swap_cnt); end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_ascending();
    logic [7:0] e;
    shadow = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd0, 8'd6, 8'd2, 8'd4};
    load_shadow();
    model_sort(8, 1'b0);
    run_sort(8, 1'b0);
    checks++; if (done_pulses !== 1) begin errors++; $display("FAIL asc_done_pulses got=%0d exp=1", done_pulses); end
    checks++; if (bus.swap_cnt !== 16'(exp_swaps)) begin errors++; $display("FAIL asc_swap_cnt got=%0d exp=%0d", bus.swap_cnt, exp_swaps); end
    checks++; if (busy_cycles !== exp_cycles) begin errors++; $display("FAIL asc_busy got=%0d exp=%0d", busy_cycles, exp_cycles); end
    read_all();
    for (int a = 0; a < 8; a++) begin
      e = exp_q.pop_front();
      checks++; if (got[a] !== e || e !== 8'(a)) begin errors++; $display("FAIL asc_data[%0d] got=%0d exp=%0d", a, got[a], a); end
    end
  endtask

  task automatic test_descending_dups();
    logic [7:0] e;
    shadow = '{8'd2, 8'd9, 8'd2, 8'd0, 8'd9, 8'd1, 8'd1, 8'd5};
    load_shadow();
    model_sort(8, 1'b1);
    run_sort(8, 1'b1);
    checks++; if (done_pulses !== 1) begin errors++; $display("FAIL desc_done_pulses got=%0d exp=1", done_pulses); end
    checks++; if (bus.swap_cnt !== 16'(exp_swaps)) begin errors++; $display("FAIL desc_swap_cnt got=%0d exp=%0d", bus.swap_cnt, exp_swaps); end
    checks++; if (busy_cycles !== exp_cycles) begin errors++; $display("FAIL desc_busy got=%0d exp=%0d", busy_cycles, exp_cycles); end
    read_all();
    for (int a = 0; a < 8; a++) begin
      e = exp_q.pop_front();
      checks++; if (got[a] !== e) begin errors++; $display("FAIL desc_data[%0d] got=%0d exp=%0d", a, got[a], e); end
    end
  endtask

  task automatic test_early_exit();
    logic [7:0] e;
    shadow = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    load_shadow();
    model_sort(8, 1'b0);
    run_sort(8, 1'b0);
    checks++; if (busy_cycles !== 24) begin errors++; $display("FAIL early_busy got=%0d exp=24", busy_cycles); end
    checks++; if (bus.swap_cnt !== 16'd0) begin errors++; $display("FAIL early_swap_cnt got=%0d exp=0", bus.swap_cnt); end
    read_all();
    for (int a = 0; a < 8; a++) begin
      e = exp_q.pop_front();
      checks++; if (got[a] !== e) begin errors++; $display("FAIL early_data[%0d] got=%0d exp=%0d", a, got[a], e); end
    end
  endtask

  task automatic test_partial_clamp();
    logic [7:0] e;
    // len=3: only the first three words move
    shadow = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    load_shadow();
    model_sort(3, 1'b0);
    run_sort(3, 1'b0);
    checks++; if (bus.swap_cnt !== 16'(exp_swaps)) begin errors++; $display("FAIL part_swap_cnt got=%0d exp=%0d", bus.swap_cnt, exp_swaps); end
    checks++; if (busy_cycles !== exp_cycles) begin errors++; $display("FAIL part_busy got=%0d exp=%0d", busy_cycles, exp_cycles); end
    read_all();
    for (int a = 0; a < 8; a++) begin
      e = exp_q.pop_front();
      checks++; if (got[a] !== e) begin errors++; $display("FAIL part_data[%0d] got=%0d exp=%0d", a, got[a], e); end
    end
    // len=15 clamps to the full depth
    shadow = '{8'd200, 8'd17, 8'd255, 8'd0, 8'd99, 8'd17, 8'd128, 8'd64};
    load_shadow();
    model_sort(15, 1'b0);
    run_sort(15, 1'b0);
    checks++; if (bus.swap_cnt !== 16'(exp_swaps)) begin errors++; $display("FAIL clamp_swap_cnt got=%0d exp=%0d", bus.swap_cnt, exp_swaps); end
    checks++; if (busy_cycles !== exp_cycles) begin errors++; $display("FAIL clamp_busy got=%0d exp=%0d", busy_cycles, exp_cycles); end
    read_all();
    for (int a = 0; a < 8; a++) begin
      e = exp_q.pop_front();
      checks++; if (got[a] !== e) begin errors++; $display("FAIL clamp_data[%0d] got=%0d exp=%0d", a, got[a], e); end
    end
    // len=1: INIT then DONE
    shadow = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4};
    load_shadow();
    model_sort(1, 1'b0);
    run_sort(1, 1'b0);
    checks++; if (done_at !== 2) begin errors++; $display("FAIL len1_done_at got=%0d exp=2", done_at); end
    checks++; if (busy_cycles !== 2) begin errors++; $display("FAIL len1_busy got=%0d exp=2", busy_cycles); end
    read_all();
    for (int a = 0; a < 8; a++) begin
      e = exp_q.pop_front();
      checks++; if (got[a] !== e) begin errors++; $display("FAIL len1_data[%0d] got=%0d exp=%0d", a, got[a], e); end
    end
  endtask

  task automatic test_interference();
    logic [7:0] e;
    shadow = '{8'd40, 8'd30, 8'd20, 8'd10, 8'd70, 8'd60, 8'd50, 8'd33};
    load_shadow();
    bus.rd = 1'b1; bus.addr = 3'd0;
    @(posedge clk); #1;
    bus.rd = 1'b0;
    checks++; if (bus.rdata !== 8'd40) begin errors++; $display("FAIL intf_preread got=%0d exp=40", bus.rdata); end
    model_sort(8, 1'b0);
    bus.len = 4'd8; bus.desc = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    done_pulses = 0;
    repeat (3) @(posedge clk);
    #1;
    bus.wr = 1'b1; bus.rd = 1'b1; bus.start = 1'b1;
    bus.addr = 3'd3; bus.wdata = 8'hEE; bus.len = 4'd2; bus.desc = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.done) done_pulses++;
    end
    checks++; if (bus.rdata !== 8'd0) begin errors++; $display("FAIL intf_rdata_busy got=%0d exp=0", bus.rdata); end
    bus.wr = 1'b0; bus.rd = 1'b0; bus.start = 1'b0;
    for (int i = 0; i < 600 && bus.busy; i++) begin
      @(posedge clk); #1;
      if (bus.done) done_pulses++;
    end
    checks++; if (done_pulses !== 1) begin errors++; $display("FAIL intf_done_pulses got=%0d exp=1", done_pulses); end
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL intf_no_restart busy=%b exp=0", bus.busy); end
    checks++; if (bus.swap_cnt !== 16'(exp_swaps)) begin errors++; $display("FAIL intf_swap_cnt got=%0d exp=%0d", bus.swap_cnt, exp_swaps); end
    read_all();
    for (int a = 0; a < 8; a++) begin
      e = exp_q.pop_front();
      checks++; if (got[a] !== e) begin errors++; $display("FAIL intf_data[%0d] got=%0d exp=%0d", a, got[a], e); end
    end
  endtask

  task automatic test_reset_mid_sort();
    logic [7:0] e;
    shadow = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    load_shadow();
    bus.len = 4'd8; bus.desc = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.swap_cnt !== 16'd0) begin errors++; $display("FAIL midrst_swap_cnt got=%0d exp=0", bus.swap_cnt); end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    shadow = '{8'd12, 8'd250, 8'd3, 8'd3, 8'd77, 8'd1, 8'd190, 8'd45};
    load_shadow();
    model_sort(8, 1'b1);
    run_sort(8, 1'b1);
    checks++; if (done_pulses !== 1) begin errors++; $display("FAIL midrst_done_pulses got=%0d exp=1", done_pulses); end
    checks++; if (bus.swap_cnt !== 16'(exp_swaps)) begin errors++; $display("FAIL midrst_resort_swaps got=%0d exp=%0d", bus.swap_cnt, exp_swaps); end
    read_all();
    for (int a = 0; a < 8; a++) begin
      e = exp_q.pop_front();
      checks++; if (got[a] !== e) begin errors++; $display("FAIL midrst_data[%0d] got=%0d exp=%0d", a, got[a], e); end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.desc = 1'b0; bus.len = '0;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = '0; bus.wdata = '0;
    test_reset();
    test_ascending();
    test_descending_dups();
    test_early_exit();
    test_partial_clamp();
    test_interference();
    test_reset_mid_sort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
